// File: rtl/add_mul_accum_4_bit.sv
// Burst multiply-accumulate front end for add_mul_combine_4_bit: registers operand pairs,
// sums the returned products over BURST_LEN pairs. Define ADD_MUL_ACCUM_SAT_EN to clamp instead of wrap.
module add_mul_accum_4_bit #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic        clear,
  output logic [3:0]  op_a_o,
  output logic [3:0]  op_b_o,
  input  logic [7:0]  mul_i,
  input  logic [3:0]  add_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_acc,
  output logic [3:0]  out_add,
  output logic        out_ovf
);

  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;

  state_t      state, state_nxt;
  logic [11:0] acc;
  logic [7:0]  cnt;
  logic        ovf;
  logic [3:0]  last_add;
  logic [12:0] acc_sum;
  logic        burst_done;

  // Bit 12 of the result is the carry out of the 12-bit accumulator.
  function automatic logic [12:0] accum(input logic [11:0] acc_v, input logic [7:0] mul_v);
    logic [12:0] s;
    s = {1'b0, acc_v} + {5'b0, mul_v};
`ifdef ADD_MUL_ACCUM_SAT_EN
    if (s[12]) s[11:0] = 12'hFFF;
`endif
    return s;
  endfunction

  assign acc_sum    = accum(acc, mul_i);
  assign burst_done = (({1'b0, cnt} + 9'd1) == 9'(BURST_LEN));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CAPTURE;
      CAPTURE: state_nxt = burst_done ? EMIT : IDLE;
      EMIT:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      last_add <= '0;
      op_a_o   <= '0;
      op_b_o   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // A pair arriving with clear becomes the first pair of the new burst.
          if (clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
          if (in_valid) begin
            op_a_o <= a;
            op_b_o <= b;
          end
        end
        CAPTURE: begin
          acc      <= acc_sum[11:0];
          ovf      <= ovf | acc_sum[12];
          last_add <= add_i;
          cnt      <= cnt + 8'd1;
        end
        EMIT: begin
          if (out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_acc   = out_valid ? acc : 12'd0;
  assign out_add   = out_valid ? last_add : 4'd0;
  assign out_ovf   = out_valid & ovf;

endmodule

// File: tb/tb_add_mul_accum_4_bit.sv
// Bench for add_mul_accum_4_bit: a 4-pair and a 19-pair instance, each fed by a behavioural
// model of the combinational add/multiply block.
module tb_add_mul_accum_4_bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_ready [2];
  logic        clear    [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic        out_ovf  [2];
  logic [3:0]  a        [2];
  logic [3:0]  b        [2];
  logic [3:0]  op_a     [2];
  logic [3:0]  op_b     [2];
  logic [3:0]  add_c    [2];
  logic [3:0]  out_add  [2];
  logic [7:0]  mul_c    [2];
  logic [11:0] out_acc  [2];

  int n_cmp = 0;
  int n_bad = 0;

  assign mul_c[0] = {4'b0, op_a[0]} * {4'b0, op_b[0]};
  assign add_c[0] = op_a[0] + op_b[0];
  assign mul_c[1] = {4'b0, op_a[1]} * {4'b0, op_b[1]};
  assign add_c[1] = op_a[1] + op_b[1];

  add_mul_accum_4_bit #(.BURST_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .clear(clear[0]), .op_a_o(op_a[0]), .op_b_o(op_b[0]),
    .mul_i(mul_c[0]), .add_i(add_c[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_acc(out_acc[0]), .out_add(out_add[0]), .out_ovf(out_ovf[0])
  );

  add_mul_accum_4_bit #(.BURST_LEN(19)) u_dut19 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .clear(clear[1]), .op_a_o(op_a[1]), .op_b_o(op_b[1]),
    .mul_i(mul_c[1]), .add_i(add_c[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_acc(out_acc[1]), .out_add(out_add[1]), .out_ovf(out_ovf[1])
  );

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [11:0] acc;
    logic [3:0]  add;
    logic        ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input int d, input logic [3:0] av, input logic [3:0] bv, input logic clr);
    int t = 0;
    while (!in_ready[d] && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready[d]) chk("in_ready_timeout", {31'd0, in_ready[d]}, 32'd1);
    in_valid[d] = 1'b1;
    a[d] = av;
    b[d] = bv;
    clear[d] = clr;
    tick();
    in_valid[d] = 1'b0;
    clear[d] = 1'b0;
  endtask

  task automatic run_burst(input int d, input int n, input logic [3:0] av, input logic [3:0] bv);
    for (int i = 0; i < n; i++) send_pair(d, av, bv, 1'b0);
  endtask

  task automatic wait_valid(input int d, input string name);
    int t = 0;
    while (!out_valid[d] && t < 50) begin
      tick();
      t++;
    end
    chk({name, "_valid"}, {31'd0, out_valid[d]}, 32'd1);
  endtask

  task automatic get_result(input int d, input logic [11:0] ea, input logic [3:0] ead,
                            input logic eo, input int hold, input string name);
    wait_valid(d, name);
    repeat (hold) tick();
    chk({name, "_acc"}, {20'd0, out_acc[d]}, {20'd0, ea});
    chk({name, "_add"}, {28'd0, out_add[d]}, {28'd0, ead});
    chk({name, "_ovf"}, {31'd0, out_ovf[d]}, {31'd0, eo});
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk({name, "_drop"}, {31'd0, out_valid[d]}, 32'd0);
    chk({name, "_acc0"}, {20'd0, out_acc[d]}, 32'd0);
    chk({name, "_rdy"}, {31'd0, in_ready[d]}, 32'd1);
  endtask

  initial begin
    int unsigned sum;
    logic [3:0] av, bv, la;
    logic [11:0] ea;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  acc: 12'h03C, add: 4'h8, ovf: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd15, acc: 12'h384, add: 4'hE, ovf: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  acc: 12'h000, add: 4'h0, ovf: 1'b0};
    vecs[3] = '{a: 4'd1,  b: 4'd1,  acc: 12'h004, add: 4'h2, ovf: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd9,  acc: 12'h0FC, add: 4'h0, ovf: 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; clear[d] = 1'b0; out_ready[d] = 1'b0;
      a[d] = 4'hF; b[d] = 4'hF;
    end
    tick();
    chk("rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("rst_op_a", {28'd0, op_a[0]}, 32'd0);
    chk("rst_op_b", {28'd0, op_b[0]}, 32'd0);
    chk("rst_acc", {20'd0, out_acc[0]}, 32'd0);
    chk("rst19_in_ready", {31'd0, in_ready[1]}, 32'd1);
    rst = 1'b0;

    // Table-driven 4-pair bursts.
    for (int i = 0; i < 5; i++)
      begin
        run_burst(0, 4, vecs[i].a, vecs[i].b);
        get_result(0, vecs[i].acc, vecs[i].add, vecs[i].ovf, i % 3, $sformatf("vec%0d", i));
      end

    // Consumer always ready: out_valid lasts exactly one cycle, one edge after the last pair.
    out_ready[0] = 1'b1;
    run_burst(0, 4, 4'd3, 4'd5);
    tick();
    chk("rdy_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("rdy_acc", {20'd0, out_acc[0]}, 32'h03C);
    chk("rdy_add", {28'd0, out_add[0]}, 32'h8);
    tick();
    chk("rdy_one_cycle", {31'd0, out_valid[0]}, 32'd0);
    out_ready[0] = 1'b0;

    // Backpressure in EMIT with a pending pair offered.
    run_burst(0, 4, 4'd3, 4'd5);
    wait_valid(0, "bp");
    in_valid[0] = 1'b1; a[0] = 4'd9; b[0] = 4'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, out_valid[0]}, 32'd1);
      chk("bp_acc", {20'd0, out_acc[0]}, 32'h03C);
      chk("bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
      chk("bp_op_a", {28'd0, op_a[0]}, 32'd3);
    end
    in_valid[0] = 1'b0;
    get_result(0, 12'h03C, 4'h8, 1'b0, 0, "bp_rel");

    // Reset during CAPTURE of the second pair.
    send_pair(0, 4'd2, 4'd3, 1'b0);
    send_pair(0, 4'd2, 4'd3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("mid_rst_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("mid_rst_op_a", {28'd0, op_a[0]}, 32'd0);
    chk("mid_rst_op_b", {28'd0, op_b[0]}, 32'd0);
    chk("mid_rst_add", {28'd0, out_add[0]}, 32'd0);
    run_burst(0, 4, 4'd1, 4'd1);
    get_result(0, 12'h004, 4'h2, 1'b0, 1, "post_rst");

    // Clear alone in IDLE.
    run_burst(0, 2, 4'd2, 4'd2);
    tick();
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    run_burst(0, 4, 4'd1, 4'd2);
    get_result(0, 12'h008, 4'h3, 1'b0, 0, "clr_idle");

    // Clear together with a pair: that pair starts the new burst.
    run_burst(0, 2, 4'd2, 4'd2);
    send_pair(0, 4'd1, 4'd2, 1'b1);
    run_burst(0, 3, 4'd1, 4'd2);
    get_result(0, 12'h008, 4'h3, 1'b0, 0, "clr_pair");

    // Clear in CAPTURE and in EMIT is ignored.
    send_pair(0, 4'd2, 4'd2, 1'b0);
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    run_burst(0, 3, 4'd1, 4'd2);
    wait_valid(0, "clr_emit");
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    get_result(0, 12'h00A, 4'h3, 1'b0, 0, "clr_ignored");

    // 19-pair overflow burst.
`ifdef ADD_MUL_ACCUM_SAT_EN
    ea = 12'hFFF;
`else
    ea = 12'h0B3;
`endif
    run_burst(1, 19, 4'd15, 4'd15);
    get_result(1, ea, 4'hE, 1'b1, 2, "ovf19");

    // Randomized bursts against a sum-of-products model.
    for (int k = 0; k < 24; k++) begin
      int d;
      int n;
      d = (k % 6 == 5) ? 1 : 0;
      n = (d == 1) ? 19 : 4;
      sum = 0;
      la = 4'd0;
      for (int i = 0; i < n; i++) begin
        av = 4'($urandom_range(0, 15));
        bv = 4'($urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) tick();
        send_pair(d, av, bv, 1'b0);
        sum += av * bv;
        la = 4'((av + bv) % 16);
      end
`ifdef ADD_MUL_ACCUM_SAT_EN
      ea = (sum > 4095) ? 12'hFFF : 12'(sum);
`else
      ea = 12'(sum % 4096);
`endif
      get_result(d, ea, la, (sum > 4095), $urandom_range(0, 3), $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
